// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: command side plus result side.
// No logic or latency of its own; it only carries the signals.
// Source drives the operands and out_ready; the ALU drives the ready/valid/result side.
// Optional abort wire present only when SEQ_ALU_ABORT_EN is defined.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     inputA;
    logic [WIDTH-1:0]     inputB;
    logic [3:0]           command;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic [1:0]           error;
    logic                 busy;
`ifdef SEQ_ALU_ABORT_EN
    logic                 abort;

    modport master (
        output in_valid, inputA, inputB, command, out_ready, abort,
        input  in_ready, out_valid, result, error, busy
    );

    modport slave (
        input  in_valid, inputA, inputB, command, out_ready, abort,
        output in_ready, out_valid, result, error, busy
    );
`else
    modport master (
        output in_valid, inputA, inputB, command, out_ready,
        input  in_ready, out_valid, result, error, busy
    );

    modport slave (
        input  in_valid, inputA, inputB, command, out_ready,
        output in_ready, out_valid, result, error, busy
    );
`endif
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: add/sub/mul/div/mod on WIDTH-bit unsigned operands, 2*WIDTH result, {dbz,overflow} error.
// Latency: add/sub/null/divide-by-zero 1 cycle after accept; mul/div/mod WIDTH+1 cycles (one bit per cycle).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional abort via SEQ_ALU_ABORT_EN.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    seq_alu_if.slave    bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    // Operand / iteration registers. r_hi:r_lo is the mul accumulator
    // ({upper half, multiplier being shifted out}) or the divider's
    // {remainder, quotient} pair; r_opa is the multiplicand, r_opb the divisor.
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [3:0]           r_cmd;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic [1:0]           r_error;

    logic                 w_accept;
    logic                 w_abort;
    logic                 w_last;
    logic                 w_dbz;
    logic                 w_iter_cmd;

    logic [WIDTH:0]       w_add;
    logic [WIDTH-1:0]     w_sub;
    logic                 w_add_ovf;
    logic                 w_sub_ovf;
    logic [2*WIDTH-1:0]   w_imm_result;
    logic [1:0]           w_imm_error;

    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH-1:0]     w_mul_hi;
    logic [WIDTH-1:0]     w_mul_lo;

    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH+1:0]     w_div_diff;
    logic                 w_div_neg;
    logic [WIDTH-1:0]     w_div_rem;
    logic [WIDTH-1:0]     w_div_quot;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_busy;

`ifdef SEQ_ALU_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept   = bus.in_valid && (r_state == S_IDLE);
    assign w_last     = (r_cnt == CW'(1));
    assign w_dbz      = (bus.inputB == '0);
    assign w_iter_cmd = (bus.command == 4'd3) ||
                        (((bus.command == 4'd4) || (bus.command == 4'd5)) && !w_dbz);

    // Single-cycle ops: carry lands in bit WIDTH for add; sub wraps mod 2^WIDTH.
    // Signed overflow: operand MSBs agree but the sum MSB differs (B inverted for sub).
    assign w_add     = {1'b0, bus.inputA} + {1'b0, bus.inputB};
    assign w_sub     = bus.inputA - bus.inputB;
    assign w_add_ovf = (bus.inputA[WIDTH-1] == bus.inputB[WIDTH-1]) &&
                       (w_add[WIDTH-1] != bus.inputA[WIDTH-1]);
    assign w_sub_ovf = (bus.inputA[WIDTH-1] != bus.inputB[WIDTH-1]) &&
                       (w_sub[WIDTH-1] != bus.inputA[WIDTH-1]);

    // Result/error for ops that finish at accept (add, sub, null, divide by zero).
    always_comb begin
        w_imm_result = '0;
        w_imm_error  = 2'b00;
        case (bus.command)
            4'd1: begin
                w_imm_result = {{(WIDTH-1){1'b0}}, w_add};
                w_imm_error  = {1'b0, w_add_ovf};
            end
            4'd2: begin
                w_imm_result = {{WIDTH{1'b0}}, w_sub};
                w_imm_error  = {1'b0, w_sub_ovf};
            end
            4'd4, 4'd5: begin
                if (w_dbz) begin
                    w_imm_error = 2'b10;
                end
            end
            default: begin
                w_imm_result = '0;
                w_imm_error  = 2'b00;
            end
        endcase
    end

    // One shift-add multiply step: add A into the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right by one.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // One restoring-divide step: shift {rem,quot} left, trial-subtract B.
    // The remainder is always < B, so the shifted value fits WIDTH+1 bits and
    // the restored value fits back into WIDTH bits.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};
    assign w_div_neg   = w_div_diff[WIDTH+1];
    assign w_div_rem   = w_div_neg ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
    assign w_div_quot  = {r_lo[WIDTH-2:0], ~w_div_neg};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.command == 4'd3) begin
                        w_next_state = S_MUL;
                    end else if (w_iter_cmd) begin
                        w_next_state = S_DIV;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake and status outputs, decoded from the current state only.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE:        w_in_ready  = 1'b1;
            S_MUL, S_DIV:  w_busy      = 1'b1;
            S_DONE:        w_out_valid = 1'b1;
            default:       w_in_ready  = 1'b0;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.result    = r_result;
    assign bus.error     = r_error;

    // Datapath: latch operands at accept, iterate in MUL/DIV, register the
    // final result. An aborted op leaves result/error untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cmd    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opa <= bus.inputA;
                        r_opb <= bus.inputB;
                        r_cmd <= bus.command;
                        r_cnt <= CW'(WIDTH);
                        r_hi  <= '0;
                        r_lo  <= (bus.command == 4'd3) ? bus.inputB : bus.inputA;
                        if (!w_iter_cmd) begin
                            r_result <= w_imm_result;
                            r_error  <= w_imm_error;
                        end
                    end
                end
                S_MUL: begin
                    if (!w_abort) begin
                        r_hi  <= w_mul_hi;
                        r_lo  <= w_mul_lo;
                        r_cnt <= r_cnt - CW'(1);
                        if (w_last) begin
                            r_result <= {w_mul_hi, w_mul_lo};
                            r_error  <= 2'b00;
                        end
                    end
                end
                S_DIV: begin
                    if (!w_abort) begin
                        r_hi  <= w_div_rem;
                        r_lo  <= w_div_quot;
                        r_cnt <= r_cnt - CW'(1);
                        if (w_last) begin
                            r_result <= (r_cmd == 4'd5) ? {{WIDTH{1'b0}}, w_div_rem}
                                                        : {{WIDTH{1'b0}}, w_div_quot};
                            r_error  <= 2'b00;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule
